// File: rtl/shift_load_controller.sv
// ----------------------------------------------------------------------------
// shift_load_controller
//
// Purpose:
//   Serial loader for a downstream shift_register. A parallel word is taken
//   over a valid/ready handshake, then shifted out one bit per cycle on
//   sr_shift_en/sr_data_in for one frame. After the frame, a one-cycle
//   sr_latch strobe marks the point where the shift_register's data_out
//   holds the complete word.
//
// Optional feature (compile-time macro SHIFT_LOAD_PARITY_EN):
//   When the macro is defined, one even-parity bit (^word) is added after
//   the data bits. The frame is then WIDTH+1 bits long, and the downstream
//   shift_register must be WIDTH+1 wide. When the macro is not defined, the
//   frame is WIDTH bits long and no parity logic is built.
//
// Parameters:
//   WIDTH      word width
//   MSB_FIRST  1: bit WIDTH-1 is shifted first; 0: bit 0 is shifted first
//   CNT_WIDTH  width of the completed-frame counter
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   in_valid     in   a word is offered
//   in_data      in   the offered word; sampled only on accept
//   in_ready     out  combinational: IDLE and no abort
//   abort        in   synchronous frame cancel
//   sr_shift_en  out  shift enable to the shift_register (registered)
//   sr_data_in   out  serial data to the shift_register (registered)
//   sr_latch     out  one-cycle strobe: frame complete
//   busy         out  high in SHIFT and LATCH
//   frame_count  out  count of completed frames; wraps around
// ----------------------------------------------------------------------------
module shift_load_controller #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  input  logic                 abort,
  output logic                 sr_shift_en,
  output logic                 sr_data_in,
  output logic                 sr_latch,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frame_count
);

`ifdef SHIFT_LOAD_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int BCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t                 state_q;
  logic [FRAME_LEN-1:0]   frame_q;
  logic [FRAME_LEN-1:0]   frame_d;
  logic [BCW-1:0]         bit_cnt_q;
  logic                   shift_en_q;
  logic                   data_in_q;
  logic                   latch_q;
  logic                   busy_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]       ordered;
  logic                   accept;

  // The captured frame is stored in transmit order with the first bit at
  // index 0. This way, each shift step only has to look at frame_q[0] and
  // then shift the frame right. No variable bit-select is needed.
  always_comb begin
    ordered = in_data;
    if (MSB_FIRST != 0) begin
      ordered = {<<{in_data}};
    end
  end

  always_comb begin
    frame_d = '0;
`ifdef SHIFT_LOAD_PARITY_EN
    // The parity bit is at the top, so it is always shifted out last.
    frame_d = {^in_data, ordered};
`else
    frame_d = ordered;
`endif
  end

  assign in_ready = (state_q == IDLE) && !abort;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      shift_en_q <= 1'b0;
      data_in_q  <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= SHIFT;
            // Present the first bit now. Keep the remaining bits, already
            // shifted down, for the following cycles.
            frame_q    <= frame_d >> 1;
            bit_cnt_q  <= BCW'(FRAME_LEN - 1);
            shift_en_q <= 1'b1;
            data_in_q  <= frame_d[0];
            busy_q     <= 1'b1;
          end
        end

        SHIFT: begin
          if (abort) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            shift_en_q <= 1'b0;
            data_in_q  <= 1'b0;
            busy_q     <= 1'b0;
          end else if (bit_cnt_q == '0) begin
            // The last frame bit is sampled downstream on this edge.
            state_q    <= LATCH;
            shift_en_q <= 1'b0;
            data_in_q  <= 1'b0;
            latch_q    <= 1'b1;
          end else begin
            data_in_q  <= frame_q[0];
            frame_q    <= frame_q >> 1;
            bit_cnt_q  <= bit_cnt_q - 1'b1;
          end
        end

        LATCH: begin
          state_q   <= IDLE;
          latch_q   <= 1'b0;
          busy_q    <= 1'b0;
          frame_q   <= '0;
          bit_cnt_q <= '0;
          // An abort in the LATCH cycle cancels the completion, so the
          // frame is not counted.
          if (!abort) begin
            count_q <= count_q + CNT_WIDTH'(1);
          end
        end

        default: begin
          state_q    <= IDLE;
          frame_q    <= '0;
          bit_cnt_q  <= '0;
          shift_en_q <= 1'b0;
          data_in_q  <= 1'b0;
          latch_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign sr_shift_en = shift_en_q;
  assign sr_data_in  = data_in_q;
  assign sr_latch    = latch_q;
  assign busy        = busy_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_shift_load_controller.sv
module tb_shift_load_controller;

`ifdef SHIFT_LOAD_PARITY_EN
  localparam int FL = 9;
  localparam logic [FL-1:0] E_A5  = 9'h14A;
  localparam logic [FL-1:0] E_3C  = 9'h078;
  localparam logic [FL-1:0] E_C3  = 9'h186;
  localparam logic [FL-1:0] E_01  = 9'h003;
  localparam logic [FL-1:0] E_07  = 9'h00F;
  localparam logic [FL-1:0] E_03  = 9'h006;
  localparam logic [FL-1:0] E_L01 = 9'h101;
`else
  localparam int FL = 8;
  localparam logic [FL-1:0] E_A5  = 8'hA5;
  localparam logic [FL-1:0] E_3C  = 8'h3C;
  localparam logic [FL-1:0] E_C3  = 8'hC3;
  localparam logic [FL-1:0] E_01  = 8'h01;
  localparam logic [FL-1:0] E_07  = 8'h07;
  localparam logic [FL-1:0] E_03  = 8'h03;
  localparam logic [FL-1:0] E_L01 = 8'h80;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        abort = 1'b0;
  logic        sr_shift_en, sr_data_in, sr_latch, busy;
  logic [15:0] frame_count;

  logic        in_valid_l = 1'b0;
  logic [7:0]  in_data_l = '0;
  logic        in_ready_l;
  logic        abort_l = 1'b0;
  logic        sr_shift_en_l, sr_data_in_l, sr_latch_l, busy_l;
  logic [15:0] frame_count_l;

  logic [FL-1:0] sr_q, sr_l_q;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [FL-1:0] data;
    logic [15:0]   cnt;
  } exp_t;
  exp_t q[$];
  exp_t ql[$];
  bit   pend = 0;
  time  acc_time;

  always #5 clock = ~clock;

  shift_load_controller #(.WIDTH(8), .MSB_FIRST(1), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .abort(abort), .sr_shift_en(sr_shift_en),
    .sr_data_in(sr_data_in), .sr_latch(sr_latch), .busy(busy),
    .frame_count(frame_count)
  );

  shift_load_controller #(.WIDTH(8), .MSB_FIRST(0), .CNT_WIDTH(16)) dut_l (
    .clock(clock), .reset(reset), .in_valid(in_valid_l), .in_data(in_data_l),
    .in_ready(in_ready_l), .abort(abort_l), .sr_shift_en(sr_shift_en_l),
    .sr_data_in(sr_data_in_l), .sr_latch(sr_latch_l), .busy(busy_l),
    .frame_count(frame_count_l)
  );

  // Downstream shift_register models.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sr_q <= '0;
    else if (sr_shift_en) sr_q <= {sr_q[FL-2:0], sr_data_in};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sr_l_q <= '0;
    else if (sr_shift_en_l) sr_l_q <= {sr_l_q[FL-2:0], sr_data_in_l};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer a word and wait for it to be accepted. The expected frame is
  // pushed to the scoreboard at the accept edge.
  task automatic send(input logic [7:0] w, input bit hold, input bit push,
                      input logic [FL-1:0] exp_data, input logic [15:0] exp_cnt);
    int n = 0;
    exp_t e;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    acc_time = $time;
    if (push) begin
      e.data = exp_data;
      e.cnt  = exp_cnt;
      q.push_back(e);
    end
    #1;
    chk("first_bit", {31'd0, sr_data_in}, {31'd0, w[7]});
    if (!hold) in_valid = 1'b0;
    in_data = ~w;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || ql.size() != 0 || pend) && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("drain", q.size() + ql.size(), 32'd0);
  endtask

  // Scoreboard monitor for the MSB-first DUT.
  initial begin : mon
    int   run = 0;
    logic [15:0] pend_cnt = '0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        run = 0;
        pend = 0;
      end else begin
        if (pend) begin
          pend = 0;
          chk("latch_one_cycle", {31'd0, sr_latch}, 32'd0);
          chk("frame_count", {16'd0, frame_count}, {16'd0, pend_cnt});
        end
        if (sr_shift_en) begin
          run++;
        end else if (sr_latch) begin
          chk("shift_len", run, FL);
          chk("busy_in_latch", {31'd0, busy}, 32'd1);
          if (q.size() == 0) begin
            chk("unexpected_latch", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("data_out", {{(32-FL){1'b0}}, sr_q}, {{(32-FL){1'b0}}, e.data});
            pend_cnt = e.cnt;
            pend = 1;
          end
          run = 0;
        end else begin
          run = 0;
        end
      end
    end
  end

  // Scoreboard monitor for the LSB-first DUT.
  initial begin : mon_l
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && sr_latch_l) begin
        if (ql.size() == 0) begin
          chk("unexpected_latch_lsb", 32'd1, 32'd0);
        end else begin
          e = ql.pop_front();
          chk("data_out_lsb", {{(32-FL){1'b0}}, sr_l_q}, {{(32-FL){1'b0}}, e.data});
          chk("busy_lsb", {31'd0, busy_l}, 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    time t0;
    int n;
    exp_t e;
    repeat (3) @(negedge clock);
    chk("rst_shift_en", {31'd0, sr_shift_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {16'd0, frame_count}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Assert reset in the middle of a frame: the outputs must clear at once,
    // before the next clock edge, and no latch strobe may follow.
    send(8'h5A, 0, 0, '0, '0);
    repeat (3) @(posedge clock);
    #2;
    chk("busy_before_rst", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_shift_en", {31'd0, sr_shift_en}, 32'd0);
    chk("async_data_in", {31'd0, sr_data_in}, 32'd0);
    chk("async_latch", {31'd0, sr_latch}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    chk("count_after_rst", {16'd0, frame_count}, 32'd0);

    // Single word.
    send(8'hA5, 0, 1, E_A5, 16'd1);
    drain();

    // Back-to-back words with in_valid held high, starting from a fresh count.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    send(8'h3C, 1, 1, E_3C, 16'd1);
    t0 = acc_time;
    send(8'hC3, 0, 1, E_C3, 16'd2);
    chk("b2b_period", 32'((acc_time - t0) / 10), FL + 2);
    drain();

    // Abort on the 4th shift cycle: no latch strobe, count unchanged.
    send(8'hFF, 0, 0, '0, '0);
    repeat (3) @(negedge clock);
    abort = 1'b1;
    @(posedge clock); #1;
    chk("abort_shift_en", {31'd0, sr_shift_en}, 32'd0);
    chk("abort_data_in", {31'd0, sr_data_in}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_blocks_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    abort = 1'b0;
    #1;
    chk("ready_after_abort", {31'd0, in_ready}, 32'd1);
    chk("count_after_abort", {16'd0, frame_count}, 32'd2);
    repeat (FL + 2) @(negedge clock);
    send(8'h01, 0, 1, E_01, 16'd3);
    drain();

    // Words that exercise the parity bit (odd and even number of ones).
    send(8'h07, 0, 1, E_07, 16'd4);
    send(8'h03, 0, 1, E_03, 16'd5);
    drain();

    // LSB-first instance.
    @(negedge clock);
    in_valid_l = 1'b1;
    in_data_l  = 8'h01;
    n = 0;
    while (!in_ready_l && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    e.data = E_L01;
    e.cnt  = 16'd1;
    ql.push_back(e);
    #1;
    in_valid_l = 1'b0;
    chk("lsb_first_bit", {31'd0, sr_data_in_l}, 32'd1);
    drain();
    @(negedge clock);
    chk("lsb_count", {16'd0, frame_count_l}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
